// File: rtl/fetch_stage_if.sv
// Instruction-memory handshake between the fetch stage (master) and instruction memory (slave).
// Single outstanding request: a one-cycle req pulse, answered by a one-cycle rvalid.
interface fetch_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
);
  logic                  imem_req;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_rvalid, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// IF stage + IF/ID register: PC, single-outstanding imem fetch, stall/flush/redirect handling.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall_cyc / perf_killed counters.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSN   = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  fetch_stage_if.master         imem,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic [PC_WIDTH-1:0]   pc_plus4_out,
  output logic [DATA_WIDTH-1:0] ins_out,
  output logic                  ifid_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_stall_cyc,
  output logic [31:0]           perf_killed
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d, pc_inc;
  logic [DATA_WIDTH-1:0] hold_q, load_data;
  logic                  req, load, capture;
  logic [PC_WIDTH-1:0]   addr;

  // While WAIT/HOLD, pc_q is the address of the outstanding request.
  assign pc_inc = pc_q + PC_WIDTH'(4);

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req       = 1'b0;
    addr      = '0;
    load      = 1'b0;
    load_data = imem.imem_rdata;
    capture   = 1'b0;
    if (redirect_valid) begin
      pc_d = {redirect_pc[PC_WIDTH-1:2], 2'b00};
      case (state_q)
        WAIT:    state_d = imem.imem_rvalid ? IDLE : DROP;
        DROP:    state_d = imem.imem_rvalid ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: if (!stall) begin
          req     = 1'b1;
          addr    = pc_q;
          state_d = WAIT;
        end
        WAIT: if (imem.imem_rvalid) begin
          if (stall) begin
            capture = 1'b1;
            state_d = HOLD;
          end else begin
            load = 1'b1;
            pc_d = pc_inc;
            req  = 1'b1;
            addr = pc_inc;
          end
        end
        HOLD: if (!stall) begin
          load      = 1'b1;
          load_data = hold_q;
          pc_d      = pc_inc;
          state_d   = IDLE;
        end
        default: if (imem.imem_rvalid) state_d = IDLE;
      endcase
    end
    if (rst) begin
      req  = 1'b0;
      addr = '0;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = addr;

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      hold_q       <= '0;
      pc_out       <= '0;
      pc_plus4_out <= '0;
      ins_out      <= NOP_INSN;
      ifid_valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (redirect_valid)  hold_q <= '0;
      else if (capture)    hold_q <= imem.imem_rdata;
      // Bubble unless a fresh instruction lands, so decode never sees a duplicate.
      if (redirect_valid || flush) begin
        ins_out    <= NOP_INSN;
        ifid_valid <= 1'b0;
      end else if (!stall) begin
        if (load) begin
          pc_out       <= pc_q;
          pc_plus4_out <= pc_inc;
          ins_out      <= load_data;
          ifid_valid   <= 1'b1;
        end else begin
          ins_out    <= NOP_INSN;
          ifid_valid <= 1'b0;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic killed;
  assign killed = redirect_valid ? ((imem.imem_rvalid && (state_q == WAIT || state_q == DROP))
                                    || state_q == HOLD)
                                 : (imem.imem_rvalid && state_q == DROP);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched   <= '0;
      perf_stall_cyc <= '0;
      perf_killed    <= '0;
    end else begin
      if (load && !redirect_valid && !flush) perf_fetched <= perf_fetched + 32'd1;
      if (stall)  perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (killed) perf_killed    <= perf_killed + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall/hold, redirect/drop, flush, PC wrap, reset mid-WAIT.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst, stall, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out, pc_plus4_out, ins_out;
  logic        ifid_valid;
  logic [31:0] w_pc_out, w_pc_plus4_out, w_ins_out;
  logic        w_ifid_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall_cyc, perf_killed;
  logic [31:0] w_perf_fetched, w_perf_stall_cyc, w_perf_killed;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_stage_if #(.DATA_WIDTH(32), .PC_WIDTH(32)) bus ();
  fetch_stage_if #(.DATA_WIDTH(32), .PC_WIDTH(32)) bus_w ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .imem(bus),
    .pc_out(pc_out), .pc_plus4_out(pc_plus4_out), .ins_out(ins_out), .ifid_valid(ifid_valid)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall_cyc(perf_stall_cyc), .perf_killed(perf_killed)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .flush(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .imem(bus_w),
    .pc_out(w_pc_out), .pc_plus4_out(w_pc_plus4_out), .ins_out(w_ins_out),
    .ifid_valid(w_ifid_valid)
`ifdef FETCH_PERF_EN
    , .perf_fetched(w_perf_fetched), .perf_stall_cyc(w_perf_stall_cyc),
    .perf_killed(w_perf_killed)
`endif
  );

  // Main memory model: latency mem_lat cycles, data = addr>>2 except magic_addr.
  int          mem_lat = 1;
  int          m_cnt = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] magic_addr = 32'hFFFF_FFF0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == magic_addr) ? 32'hDEAD_BEEF : (a >> 2);
  endfunction

  always @(posedge clk) begin
    bus.imem_rvalid <= 1'b0;
    if (m_cnt != 0) begin
      if (m_cnt == 1) begin
        bus.imem_rvalid <= 1'b1;
        bus.imem_rdata  <= mem_data(m_addr);
      end
      m_cnt <= m_cnt - 1;
    end
    if (bus.imem_req === 1'b1) begin
      if (mem_lat == 1) begin
        bus.imem_rvalid <= 1'b1;
        bus.imem_rdata  <= mem_data(bus.imem_addr);
      end else begin
        m_cnt  <= mem_lat - 1;
        m_addr <= bus.imem_addr;
      end
    end
  end

  // Wrap-test memory: fixed 1-cycle latency, data = addr>>2.
  always @(posedge clk) begin
    bus_w.imem_rvalid <= (bus_w.imem_req === 1'b1);
    bus_w.imem_rdata  <= bus_w.imem_addr >> 2;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) cyc();
    #1;
    check("rst_valid", ifid_valid, 0);
    check("rst_ins",   ins_out, 32'h13);
    check("rst_pc",    pc_out, 0);
    check("rst_pc4",   pc_plus4_out, 0);
    check("rst_req",   bus.imem_req, 0);

    // 1: streaming with 1-cycle memory
    rst = 1'b0; #1;
    check("t1_req0",   bus.imem_req, 1);
    check("t1_addr0",  bus.imem_addr, 32'h0);
    check("t6_wreq0",  bus_w.imem_req, 1);
    check("t6_waddr0", bus_w.imem_addr, 32'hFFFF_FFFC);
    cyc(); #1;
    check("t1_addr4",  bus.imem_addr, 32'h4);
    check("t1_nvalid", ifid_valid, 0);
    check("t6_waddr1", bus_w.imem_addr, 32'h0);
    cyc(); #1;
    check("t1_pc0",    pc_out, 32'h0);
    check("t1_pc4_0",  pc_plus4_out, 32'h4);
    check("t1_ins0",   ins_out, 32'h0);
    check("t1_valid0", ifid_valid, 1);
    check("t6_wpc",    w_pc_out, 32'hFFFF_FFFC);
    check("t6_wpc4",   w_pc_plus4_out, 32'h0);
    check("t6_wins",   w_ins_out, 32'h3FFF_FFFF);
    cyc(); #1;
    check("t1_pc1",    pc_out, 32'h4);
    check("t1_ins1",   ins_out, 32'h1);
    check("t6_wpc_b",  w_pc_out, 32'h0);
    check("t6_wins_b", w_ins_out, 32'h0);
    magic_addr = 32'h10;
    cyc(); #1;
    check("t1_pc2",    pc_out, 32'h8);
    check("t1_ins2",   ins_out, 32'h2);
    check("t1_valid2", ifid_valid, 1);

    // 2: stall while the 0x10 response (0xDEADBEEF) arrives
    cyc();
    check("t2_pre_ins", ins_out, 32'h3);
    stall = 1'b1; #1;
    check("t2_noreq0", bus.imem_req, 0);
    cyc(); #1;
    check("t2_hold_pc",  pc_out, 32'hC);
    check("t2_hold_ins", ins_out, 32'h3);
    cyc(); cyc(); #1;
    check("t2_hold_ins2", ins_out, 32'h3);
    check("t2_noreq1",    bus.imem_req, 0);
    stall = 1'b0; #1;
    check("t2_noreq_hold", bus.imem_req, 0);
    cyc(); #1;
    check("t2_beef",     ins_out, 32'hDEAD_BEEF);
    check("t2_beef_pc",  pc_out, 32'h10);
    check("t2_beef_val", ifid_valid, 1);
    check("t2_resume_req",  bus.imem_req, 1);
    check("t2_resume_addr", bus.imem_addr, 32'h14);
    cyc(); #1;
    check("t2_no_dup", ifid_valid, 0);
    cyc(); #1;
    check("t2_next_pc",  pc_out, 32'h14);
    check("t2_next_ins", ins_out, 32'h5);

    // 3: latency 3, redirect while 0x10 is outstanding
    rst = 1'b1; mem_lat = 3; magic_addr = 32'hFFFF_FFF0;
    repeat (3) cyc();
    rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h12; #1;
    check("t3_redir_idle_noreq", bus.imem_req, 0);
    cyc();
    redirect_valid = 1'b0; #1;
    check("t3_req10",  bus.imem_req, 1);
    check("t3_addr10", bus.imem_addr, 32'h10);
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    check("t3_redir_noreq", bus.imem_req, 0);
    cyc();
    redirect_valid = 1'b0; #1;
    check("t3_drop_noreq", bus.imem_req, 0);
    cyc(); #1;
    check("t3_drop_noreq2", bus.imem_req, 0);
    check("t3_bubble0",     ifid_valid, 0);
    cyc(); #1;
    check("t3_req100",  bus.imem_req, 1);
    check("t3_addr100", bus.imem_addr, 32'h100);
    check("t3_bubble1", ifid_valid, 0);
    check("t3_nop1",    ins_out, 32'h13);
    cyc(); cyc(); cyc(); #1;
    check("t3_addr104", bus.imem_addr, 32'h104);
    check("t3_bubble2", ifid_valid, 0);
    cyc(); #1;
    check("t3_pc100",  pc_out, 32'h100);
    check("t3_ins100", ins_out, 32'h40);
    check("t3_val100", ifid_valid, 1);

    // 4: redirect + flush + stall + rvalid together
    cyc(); cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h100; flush = 1'b1; stall = 1'b1; #1;
    check("t4_noreq", bus.imem_req, 0);
    cyc();
    redirect_valid = 1'b0; flush = 1'b0; stall = 1'b0; #1;
    check("t4_valid", ifid_valid, 0);
    check("t4_nop",   ins_out, 32'h13);
    check("t4_req",   bus.imem_req, 1);
    check("t4_addr",  bus.imem_addr, 32'h100);

    // 5: single-cycle flush at pc 0x20
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    cyc();
    redirect_valid = 1'b0; #1;
    check("t5_addr20", bus.imem_addr, 32'h20);
    repeat (4) cyc(); #1;
    check("t5_pc20",  pc_out, 32'h20);
    check("t5_ins20", ins_out, 32'h8);
    flush = 1'b1;
    cyc();
    flush = 1'b0; #1;
    check("t5_flush_valid", ifid_valid, 0);
    check("t5_flush_nop",   ins_out, 32'h13);
    cyc(); #1;
    check("t5_addr28", bus.imem_addr, 32'h28);
    cyc(); #1;
    check("t5_pc24",  pc_out, 32'h24);
    check("t5_pc4_24", pc_plus4_out, 32'h28);
    check("t5_ins24", ins_out, 32'h9);
    check("t5_val24", ifid_valid, 1);

    // 6b: reset in WAIT, late rvalid lands in IDLE and is ignored
    rst = 1'b1;
    cyc();
    rst = 1'b0; stall = 1'b1; #1;
    check("t6_rst_valid", ifid_valid, 0);
    check("t6_rst_pc",    pc_out, 32'h0);
    check("t6_rst_req",   bus.imem_req, 0);
    cyc(); #1;
    check("t6_late_noreq", bus.imem_req, 0);
    cyc(); #1;
    check("t6_late_valid", ifid_valid, 0);
    check("t6_late_ins",   ins_out, 32'h13);
    stall = 1'b0; #1;
    check("t6_restart_req",  bus.imem_req, 1);
    check("t6_restart_addr", bus.imem_addr, 32'h0);
    repeat (4) cyc(); #1;
    check("t6_first_pc",  pc_out, 32'h0);
    check("t6_first_pc4", pc_plus4_out, 32'h4);
    check("t6_first_ins", ins_out, 32'h0);
    check("t6_first_val", ifid_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
